knn_classify_ctrl: RTL and testbench
====================================

// Module: knn_classify_ctrl
// PURPOSE
//  Sequences one k-NN classification around the 5-deep nearest_neighbour sorter.
//  - Accepts a query feature over a valid/ready handshake and clears the sorter.
//  - Streams every training sample from a sync-read ROM, computes |query - feature| and feeds
//    (distance, label) into the sorter.
//  - Majority-votes the K nearest labels and presents the class on a valid/ready output.
// PARAMETERS
//  N_TRAIN  16  number of training samples in ROM, addresses 0..N_TRAIN-1 (>=1)
//  ADDR_W    4  ROM address width, >= clog2(N_TRAIN)
//  FEAT_W    5  feature and distance width; must match the sorter data width
//  LBL_W     2  label width; N_CLASSES = 2**LBL_W
//  K         5  number of sorter slots that vote (1..5; uses labels 1..K)
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst           in   1       synchronous, active-high reset
//  query_valid   in   1       query offered
//  query_ready   out  1       controller idle, can accept a query
//  query_data    in   FEAT_W  query feature
//  mem_rd        out  1       ROM read strobe
//  mem_addr      out  ADDR_W  ROM address
//  mem_feat      in   FEAT_W  ROM feature, valid 1 cycle after mem_rd
//  mem_label     in   LBL_W   ROM label, valid 1 cycle after mem_rd
//  nn_clr        out  1       sorter clear; integrator drives sorter rst = rst | nn_clr
//  nn_enable     out  1       sorter enable
//  nn_data       out  FEAT_W  distance to sorter
//  nn_label      out  LBL_W   label to sorter
//  nn_labels     in   5*LBL_W sorter label_1..label_5; label_1 in LSBs
//  result_valid  out  1       class available; held until accepted
//  result_ready  in   1       consumer accepts the class
//  result_class  out  LBL_W   voted class
//  busy          out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; all registered outputs 0; query_ready=1 (decoded from IDLE).
//  rst at any time, including mid-run, aborts the run. Next cycle is IDLE; no result is produced.
//  States: IDLE -> CLEAR -> FETCH -> DRAIN -> VOTE -> DONE -> IDLE.
//  IDLE:
//   - query_ready=1.
//   - On query_valid&&query_ready: latch query_data and go to CLEAR.
//  CLEAR: 1 cycle; nn_clr=1.
//  FETCH: N_TRAIN cycles.
//   - mem_rd=1; mem_addr = 0,1,..,N_TRAIN-1 (internal index counter).
//   - Move to DRAIN after the cycle with addr N_TRAIN-1.
//  Pipeline, for a read in cycle t:
//   - Stage 1 (t+1): dist = |q - mem_feat| as an FEAT_W-bit unsigned abs difference
//     (no overflow possible).
//   - Registers nn_data=dist, nn_label=mem_label, nn_enable=1, visible in cycle t+2.
//   - nn_enable is the 2-cycle-delayed mem_rd. It is 0 in all other cycles.
//  DRAIN: 2 cycles, so the last enable retires and the sorter outputs settle.
//  VOTE: 1 cycle.
//   - Per-class counts over label_1..label_K.
//   - The highest count wins.
//   - Tie: the tied class that appears earliest in label_1..label_K order wins.
//   - Registers result_class.
//  DONE:
//   - result_valid=1 and result_class held stable until result_ready.
//   - Then result_valid=0 and return to IDLE next cycle.
//   - result_ready outside DONE is ignored.
//  Latency:
//   - Acceptance cycle c0 -> result_valid first high in cycle c0+N_TRAIN+5 (21 at defaults).
//   - Minimum spacing between accepts is N_TRAIN+7 cycles (1 IDLE bubble after DONE).
//  Boundaries:
//   - query_valid outside IDLE is ignored (query_ready=0).
//   - Distance 2**FEAT_W-1 is never inserted by the sorter. If no sample is inserted,
//     all slots read label 0, so result_class=0.
//   - mem_addr returns to 0 outside FETCH.
//   - N_TRAIN<K: the slots that are never filled vote as label 0.
// STRUCTURE
//  Shared package knn_pkg holds:
//   - FEAT_W, LBL_W, K_MAX=5, N_CLASSES, MAX_DIST.
//   - State encoding typedef for IDLE/CLEAR/FETCH/DRAIN/VOTE/DONE.
//  Sub-module knn_vote is a combinational majority voter.
//   - Inputs: nn_labels and K. Output: class.
//   - Counts are 3 bits; tie-break is implemented inside the voter.
//  The FSM, index counter, distance stage and result registers stay in knn_classify_ctrl.
// TESTING
//  1 ROM feat=i, label=i%4, query=0.
//    -> Nearest labels 0,1,2,3,0; result_class=0; result_valid at c0+21; nn_enable high 16 cycles.
//  2 ROM arranged so the sorted labels are 2,1,2,1,3.
//    -> Counts tie 2:2; result_class=2 (earliest in order).
//  3 result_ready held low 10 cycles in DONE, and query_valid pulsed meanwhile.
//    -> result_valid and result_class stable; query_ready=0; the pulsed query is ignored.
//  4 rst asserted while mem_addr=7.
//    -> Next cycle IDLE and all outputs 0. A new query completes in full with 1 nn_clr pulse
//       and the correct class.
//  5 All ROM features=31, query=0.
//    -> No sorter insertions; result_class=0; latency unchanged.
//  6 Two queries back-to-back with different answers (query 0 then 31).
//    -> Second class is independent of the first; accepts spaced exactly N_TRAIN+7 cycles.

Source files
------------

// File: rtl/knn_pkg.sv
// Shared widths, limits and state encoding for the k-NN classification controller.
package knn_pkg;

    localparam int FEAT_W    = 5;
    localparam int LBL_W     = 2;
    localparam int K_MAX     = 5;
    localparam int N_CLASSES = 2 ** LBL_W;
    localparam logic [FEAT_W-1:0] MAX_DIST = FEAT_W'((2 ** FEAT_W) - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_VOTE  = 3'd4,
        ST_DONE  = 3'd5
    } knn_state_e;

    function automatic logic [FEAT_W-1:0] abs_diff(input logic [FEAT_W-1:0] a,
                                                   input logic [FEAT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/knn_vote.sv
// Combinational majority voter over the first i_k sorter labels; ties go to the
// tied class whose label appears earliest in slot order.
module knn_vote
    import knn_pkg::*;
(
    input  logic [K_MAX*LBL_W-1:0] i_nn_labels,
    input  logic [2:0]             i_k,
    output logic [LBL_W-1:0]       o_class
);

    logic [2:0]       w_cnt [N_CLASSES];
    logic [2:0]       w_best_cnt;
    logic [LBL_W-1:0] w_best;
    logic [LBL_W-1:0] w_lbl;

    // count per class, then scan slots in order so a strictly larger count is needed to win
    always_comb begin
        for (int c = 0; c < N_CLASSES; c++) begin
            w_cnt[c] = 3'd0;
        end
        w_best_cnt = 3'd0;
        w_best     = {LBL_W{1'b0}};
        w_lbl      = {LBL_W{1'b0}};
        for (int i = 0; i < K_MAX; i++) begin
            w_lbl = i_nn_labels[i*LBL_W +: LBL_W];
            if (3'(i) < i_k) begin
                w_cnt[w_lbl] = w_cnt[w_lbl] + 3'd1;
            end else begin
                w_cnt[w_lbl] = w_cnt[w_lbl];
            end
        end
        for (int i = 0; i < K_MAX; i++) begin
            w_lbl = i_nn_labels[i*LBL_W +: LBL_W];
            if ((3'(i) < i_k) && (w_cnt[w_lbl] > w_best_cnt)) begin
                w_best_cnt = w_cnt[w_lbl];
                w_best     = w_lbl;
            end else begin
                w_best_cnt = w_best_cnt;
            end
        end
        o_class = w_best;
    end

endmodule

// File: rtl/knn_classify_ctrl.sv
// Sequences one k-NN classification: query accept, sorter clear, ROM sweep with
// |query - feature| distances into the sorter, majority vote and result handshake.
module knn_classify_ctrl
    import knn_pkg::*;
#(
    parameter int N_TRAIN = 16,
    parameter int ADDR_W  = 4,
    parameter int K       = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   query_valid,
    output logic                   query_ready,
    input  logic [FEAT_W-1:0]      query_data,
    output logic                   mem_rd,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [FEAT_W-1:0]      mem_feat,
    input  logic [LBL_W-1:0]       mem_label,
    output logic                   nn_clr,
    output logic                   nn_enable,
    output logic [FEAT_W-1:0]      nn_data,
    output logic [LBL_W-1:0]       nn_label,
    input  logic [K_MAX*LBL_W-1:0] nn_labels,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [LBL_W-1:0]       result_class,
    output logic                   busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_TRAIN - 1);

    knn_state_e        r_state;
    knn_state_e        w_state_next;
    logic [ADDR_W-1:0] r_idx;
    logic              r_drain;
    logic [FEAT_W-1:0] r_query;
    logic              r_rd_d1;
    logic              r_nn_enable;
    logic [FEAT_W-1:0] r_nn_data;
    logic [LBL_W-1:0]  r_nn_label;
    logic [LBL_W-1:0]  r_result_class;
    logic              r_result_valid;
    logic [LBL_W-1:0]  w_class;
    logic              w_accept;
    logic              w_fetch_last;

    assign w_accept     = (r_state == ST_IDLE) && query_valid;
    assign w_fetch_last = (r_state == ST_FETCH) && (r_idx == LAST_ADDR);

    assign query_ready  = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign mem_rd       = (r_state == ST_FETCH);
    assign mem_addr     = r_idx;
    assign nn_clr       = (r_state == ST_CLEAR);
    assign nn_enable    = r_nn_enable;
    assign nn_data      = r_nn_data;
    assign nn_label     = r_nn_label;
    assign result_valid = r_result_valid;
    assign result_class = r_result_class;

    knn_vote u_vote (
        .i_nn_labels (nn_labels),
        .i_k         (3'(K)),
        .o_class     (w_class)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state decode; DONE lingers one cycle after the handshake with result_valid low
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (query_valid) begin
                    w_state_next = ST_CLEAR;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CLEAR: w_state_next = ST_FETCH;
            ST_FETCH: begin
                if (r_idx == LAST_ADDR) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (r_drain) begin
                    w_state_next = ST_VOTE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_VOTE: w_state_next = ST_DONE;
            ST_DONE: begin
                if (!r_result_valid) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ROM index and drain counters; index parks at 0 outside FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= {ADDR_W{1'b0}};
            r_drain <= 1'b0;
        end else begin
            if ((r_state == ST_FETCH) && !w_fetch_last) begin
                r_idx <= r_idx + ADDR_W'(1);
            end else begin
                r_idx <= {ADDR_W{1'b0}};
            end
            if (r_state == ST_DRAIN) begin
                r_drain <= ~r_drain;
            end else begin
                r_drain <= 1'b0;
            end
        end
    end

    // query latch and two-stage distance pipeline to the sorter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_query     <= {FEAT_W{1'b0}};
            r_rd_d1     <= 1'b0;
            r_nn_enable <= 1'b0;
            r_nn_data   <= {FEAT_W{1'b0}};
            r_nn_label  <= {LBL_W{1'b0}};
        end else begin
            if (w_accept) begin
                r_query <= query_data;
            end else begin
                r_query <= r_query;
            end
            r_rd_d1     <= mem_rd;
            r_nn_enable <= r_rd_d1;
            if (r_rd_d1) begin
                r_nn_data  <= abs_diff(r_query, mem_feat);
                r_nn_label <= mem_label;
            end else begin
                r_nn_data  <= r_nn_data;
                r_nn_label <= r_nn_label;
            end
        end
    end

    // result registers; class captured in VOTE, valid held until accepted in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result_class <= {LBL_W{1'b0}};
            r_result_valid <= 1'b0;
        end else begin
            if (r_state == ST_VOTE) begin
                r_result_class <= w_class;
                r_result_valid <= 1'b1;
            end else if ((r_state == ST_DONE) && r_result_valid && result_ready) begin
                r_result_class <= r_result_class;
                r_result_valid <= 1'b0;
            end else begin
                r_result_class <= r_result_class;
                r_result_valid <= r_result_valid;
            end
        end
    end

endmodule

// File: tb/tb_knn_classify_ctrl.sv
// Self-checking bench: ROM and 5-deep sorter models, table-driven queries with a
// class scoreboard, plus hand sequences for result back-pressure and mid-run reset.
module tb_knn_classify_ctrl;
    import knn_pkg::*;

    localparam int N_TRAIN = 16;
    localparam int ADDR_W  = 4;
    localparam int K       = 5;
    localparam int LATENCY = N_TRAIN + 5;
    localparam int SPACING = N_TRAIN + 7;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   query_valid;
    logic                   query_ready;
    logic [FEAT_W-1:0]      query_data;
    logic                   mem_rd;
    logic [ADDR_W-1:0]      mem_addr;
    logic [FEAT_W-1:0]      mem_feat;
    logic [LBL_W-1:0]       mem_label;
    logic                   nn_clr;
    logic                   nn_enable;
    logic [FEAT_W-1:0]      nn_data;
    logic [LBL_W-1:0]       nn_label;
    logic [K_MAX*LBL_W-1:0] nn_labels;
    logic                   result_valid;
    logic                   result_ready;
    logic [LBL_W-1:0]       result_class;
    logic                   busy;

    always #5 clk = ~clk;

    knn_classify_ctrl #(.N_TRAIN(N_TRAIN), .ADDR_W(ADDR_W), .K(K)) dut (
        .clk(clk), .rst(rst),
        .query_valid(query_valid), .query_ready(query_ready), .query_data(query_data),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_feat(mem_feat), .mem_label(mem_label),
        .nn_clr(nn_clr), .nn_enable(nn_enable), .nn_data(nn_data), .nn_label(nn_label),
        .nn_labels(nn_labels),
        .result_valid(result_valid), .result_ready(result_ready), .result_class(result_class),
        .busy(busy)
    );

    logic [FEAT_W-1:0] rom_feat  [N_TRAIN];
    logic [LBL_W-1:0]  rom_label [N_TRAIN];

    // sync-read ROM model
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_feat  <= rom_feat[mem_addr];
            mem_label <= rom_label[mem_addr];
        end
    end

    logic [FEAT_W-1:0] s_dist [K_MAX];
    logic [LBL_W-1:0]  s_lbl  [K_MAX];

    function automatic int ins_pos(input logic [FEAT_W-1:0] d);
        for (int j = 0; j < K_MAX; j++) begin
            if (d < s_dist[j]) return j;
        end
        return K_MAX;
    endfunction

    // sorter model: ascending distance, a new equal distance goes after existing ones
    always @(posedge clk) begin
        if (rst || nn_clr) begin
            for (int j = 0; j < K_MAX; j++) begin
                s_dist[j] <= MAX_DIST;
                s_lbl[j]  <= '0;
            end
        end else if (nn_enable && (nn_data != MAX_DIST)) begin
            for (int j = 0; j < K_MAX; j++) begin
                if (j > ins_pos(nn_data)) begin
                    s_dist[j] <= s_dist[j-1];
                    s_lbl[j]  <= s_lbl[j-1];
                end else if (j == ins_pos(nn_data)) begin
                    s_dist[j] <= nn_data;
                    s_lbl[j]  <= nn_label;
                end
            end
        end
    end

    assign nn_labels = {s_lbl[4], s_lbl[3], s_lbl[2], s_lbl[1], s_lbl[0]};

    int cyc_g   = 0;
    int en_cnt  = 0;
    int clr_cnt = 0;

    // free-running cycle and pulse counters
    always @(posedge clk) begin
        cyc_g <= cyc_g + 1;
        if (nn_enable) en_cnt  <= en_cnt + 1;
        if (nn_clr)    clr_cnt <= clr_cnt + 1;
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [LBL_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic load_rom(input int pat);
        for (int i = 0; i < N_TRAIN; i++) begin
            case (pat)
                0: begin rom_feat[i] = FEAT_W'(i);      rom_label[i] = LBL_W'(i % 4); end
                1: begin
                    if (i < 5) begin
                        rom_feat[i] = FEAT_W'(i);
                        rom_label[i] = (i == 4) ? 2'd3 : ((i % 2 == 0) ? 2'd2 : 2'd1);
                    end else begin
                        rom_feat[i] = FEAT_W'(10 + i); rom_label[i] = 2'd0;
                    end
                end
                2: begin rom_feat[i] = MAX_DIST;         rom_label[i] = 2'd3; end
                default: begin
                    rom_feat[i]  = FEAT_W'($urandom_range(0, 31));
                    rom_label[i] = LBL_W'($urandom_range(0, 3));
                end
            endcase
        end
    endtask

    function automatic logic [LBL_W-1:0] ref_class(input logic [FEAT_W-1:0] q);
        logic [FEAT_W-1:0] d [N_TRAIN];
        bit               used [N_TRAIN];
        logic [LBL_W-1:0] lbl [K_MAX];
        int cnt [N_CLASSES];
        int m, bc;
        logic [LBL_W-1:0] best;
        for (int i = 0; i < N_TRAIN; i++) begin
            d[i] = (q >= rom_feat[i]) ? q - rom_feat[i] : rom_feat[i] - q;
            used[i] = 1'b0;
        end
        for (int s = 0; s < K_MAX; s++) begin
            m = -1;
            for (int i = 0; i < N_TRAIN; i++) begin
                if (!used[i] && d[i] != MAX_DIST && (m < 0 || d[i] < d[m])) m = i;
            end
            lbl[s] = (m < 0) ? 2'd0 : rom_label[m];
            if (m >= 0) used[m] = 1'b1;
        end
        for (int c = 0; c < N_CLASSES; c++) cnt[c] = 0;
        for (int s = 0; s < K; s++) cnt[lbl[s]]++;
        bc = 0; best = 2'd0;
        for (int s = 0; s < K; s++) begin
            if (cnt[lbl[s]] > bc) begin bc = cnt[lbl[s]]; best = lbl[s]; end
        end
        return best;
    endfunction

    // one full query; returns acceptance cycle; hold keeps result_ready low in DONE
    task automatic do_query(input logic [FEAT_W-1:0] q, input logic [LBL_W-1:0] exp,
                            input int hold, output int c0);
        int t, en0, clr0;
        logic [LBL_W-1:0] cls0;
        t = 0;
        while (!query_ready && t < 50) begin @(negedge clk); t++; end
        check("query_ready_wait", query_ready, 1);
        query_valid = 1'b1; query_data = q;
        exp_q.push_back(exp);
        c0 = cyc_g; en0 = en_cnt; clr0 = clr_cnt;
        @(negedge clk);
        query_valid = 1'b0;
        t = 1;
        while (!result_valid && t < 100) begin @(negedge clk); t++; end
        check("latency", t, LATENCY);
        check("nn_enable_cycles", en_cnt - en0, N_TRAIN);
        check("nn_clr_pulses", clr_cnt - clr0, 1);
        check("mem_addr_done", mem_addr, 0);
        cls0 = result_class;
        for (int i = 0; i < hold; i++) begin
            query_valid = (i % 2 == 0); query_data = ~q;
            check("query_ready_done", query_ready, 0);
            @(negedge clk);
            check("hold_valid", result_valid, 1);
            check("hold_class", result_class, cls0);
        end
        query_valid = 1'b0;
        result_ready = 1'b1;
        if (exp_q.size() > 0) check("class", result_class, exp_q.pop_front());
        @(negedge clk);
        result_ready = 1'b0;
        check("valid_drop", result_valid, 0);
    endtask

    typedef struct {
        int               pat;
        logic [FEAT_W-1:0] q;
        logic [LBL_W-1:0]  exp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int c0, prev_c0, t, seen;
        vecs[0] = '{pat: 0, q: 5'd0,  exp: 2'd0};
        vecs[1] = '{pat: 1, q: 5'd0,  exp: 2'd2};
        vecs[2] = '{pat: 2, q: 5'd0,  exp: 2'd0};
        vecs[3] = '{pat: 0, q: 5'd31, exp: 2'd3};

        rst = 1'b1; query_valid = 1'b0; query_data = '0; result_ready = 1'b0;
        load_rom(0);
        repeat (3) @(negedge clk);
        check("rst_query_ready", query_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_nn_enable", nn_enable, 0);
        rst = 1'b0;
        @(negedge clk);

        // table: back-to-back queries, accepts spaced by the minimum interval
        prev_c0 = 0;
        for (int v = 0; v < 4; v++) begin
            load_rom(vecs[v].pat);
            do_query(vecs[v].q, vecs[v].exp, 0, c0);
            if (v > 0) check("accept_spacing", c0 - prev_c0, SPACING);
            prev_c0 = c0;
        end

        // back-pressure in DONE with ignored query pulses
        load_rom(1);
        do_query(5'd0, 2'd2, 10, c0);
        @(negedge clk);
        check("idle_after_hold", busy, 0);

        // mid-run reset at address 7
        load_rom(0);
        query_valid = 1'b1; query_data = 5'd0;
        @(negedge clk);
        query_valid = 1'b0;
        t = 0;
        while (mem_addr != 4'd7 && t < 50) begin @(negedge clk); t++; end
        check("reach_addr7", mem_addr, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_query_ready", query_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_mem_rd", mem_rd, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_nn_enable", nn_enable, 0);
        check("abort_nn_clr", nn_clr, 0);
        check("abort_nn_data", nn_data, 0);
        check("abort_nn_label", nn_label, 0);
        check("abort_result_valid", result_valid, 0);
        check("abort_result_class", result_class, 0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        do_query(5'd0, 2'd0, 0, c0);

        // random ROMs and queries against the reference model
        for (int r = 0; r < 4; r++) begin
            logic [FEAT_W-1:0] q;
            load_rom(3);
            q = FEAT_W'($urandom_range(0, 31));
            do_query(q, ref_class(q), 0, c0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
